// File: rtl/el2_dccm_sram_sink_pkg.sv
// rtl/el2_dccm_sram_sink_pkg.sv - shared types and default geometry for the DCCM SRAM sink
// Init FSM state encoding plus default bank geometry of the DCCM.
package el2_dccm_sram_sink_pkg;

  typedef enum logic {EL2_SRAM_INIT, EL2_SRAM_READY} el2_sram_init_e;

  localparam int EL2_DCCM_NUM_BANKS  = 4;
  localparam int EL2_DCCM_BANK_BITS  = 2;
  localparam int EL2_DCCM_BITS       = 16;
  localparam int EL2_DCCM_DATA_WIDTH = 32;
  localparam int EL2_DCCM_ECC_WIDTH  = 7;

endpackage

// File: rtl/el2_dccm_sram_sink_if.sv
// rtl/el2_dccm_sram_sink_if.sv - DCCM bank port bundle between controller and SRAM sink
// master = core DCCM controller, slave = memory-side sink.
interface el2_dccm_sram_sink_if #(
  parameter int NB    = 4,
  parameter int ROW_W = 12,
  parameter int DW    = 32,
  parameter int EW    = 7
);

  logic [NB-1:0]            dccm_clken;
  logic [NB-1:0]            dccm_wren_bank;
  logic [NB-1:0][ROW_W-1:0] dccm_addr_bank;
  logic [NB-1:0][DW-1:0]    dccm_wr_data_bank;
  logic [NB-1:0][EW-1:0]    dccm_wr_ecc_bank;
  logic [NB-1:0][DW-1:0]    dccm_bank_dout;
  logic [NB-1:0][EW-1:0]    dccm_bank_ecc;

  modport master (
    output dccm_clken, dccm_wren_bank, dccm_addr_bank, dccm_wr_data_bank, dccm_wr_ecc_bank,
    input  dccm_bank_dout, dccm_bank_ecc
  );

  modport slave (
    input  dccm_clken, dccm_wren_bank, dccm_addr_bank, dccm_wr_data_bank, dccm_wr_ecc_bank,
    output dccm_bank_dout, dccm_bank_ecc
  );

endinterface

// File: rtl/el2_dccm_sram_sink_bank.sv
// rtl/el2_dccm_sram_sink_bank.sv - one DCCM bank: {ecc,data} storage with registered read port
// Storage is deliberately unreset; the parent's init sweep zero-fills it.
module el2_dccm_sram_bank #(
  parameter int ROW_W = 12,
  parameter int DW    = 32,
  parameter int EW    = 7
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [ROW_W-1:0]    addr,
  input  logic [EW+DW-1:0]    wr_data,
  input  logic [EW-1:0]       inj_mask,
  output logic [EW+DW-1:0]    rd_data
);

  localparam int ROWS = 2 ** ROW_W;

  logic [EW+DW-1:0] mem [ROWS];
  logic [EW+DW-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

  // Injection only flips the returned check bits, never the stored word.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[addr] ^ {inj_mask, {DW{1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/el2_dccm_sram_sink.sv
// rtl/el2_dccm_sram_sink.sv - DCCM SRAM sink: banks, zero-fill init FSM, one-shot ECC injection
// Core traffic is ignored until every row of every bank has been written with a zero codeword.
module el2_dccm_sram_sink
  import el2_dccm_sram_sink_pkg::*;
#(
  parameter int DCCM_NUM_BANKS  = EL2_DCCM_NUM_BANKS,
  parameter int DCCM_BANK_BITS  = EL2_DCCM_BANK_BITS,
  parameter int DCCM_BITS       = EL2_DCCM_BITS,
  parameter int DCCM_DATA_WIDTH = EL2_DCCM_DATA_WIDTH,
  parameter int DCCM_ECC_WIDTH  = EL2_DCCM_ECC_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_l,
  el2_dccm_sram_sink_if.slave       bus,
  output logic                      init_done,
  input  logic                      err_inj_valid,
  input  logic [DCCM_BANK_BITS-1:0] err_inj_bank,
  input  logic [DCCM_ECC_WIDTH-1:0] err_inj_mask,
  output logic                      err_inj_pending
);

  localparam int NB    = DCCM_NUM_BANKS;
  localparam int DW    = DCCM_DATA_WIDTH;
  localparam int EW    = DCCM_ECC_WIDTH;
  localparam int ROW_W = DCCM_BITS - DCCM_BANK_BITS - 2;
  localparam int ROWS  = 2 ** ROW_W;

  el2_sram_init_e state_q, state_d;
  logic [ROW_W-1:0]          row_cnt_q, row_cnt_d;
  logic                      inj_pending_q, inj_pending_d;
  logic [DCCM_BANK_BITS-1:0] inj_bank_q, inj_bank_d;
  logic [EW-1:0]             inj_mask_q, inj_mask_d;

  logic [NB-1:0]            bank_we;
  logic [NB-1:0]            bank_re;
  logic [NB-1:0][ROW_W-1:0] bank_addr;
  logic [NB-1:0][EW+DW-1:0] bank_wdata;
  logic [NB-1:0][EW-1:0]    bank_inj_mask;
  logic [NB-1:0][EW+DW-1:0] bank_rd;

  always_comb begin
    state_d       = state_q;
    row_cnt_d     = row_cnt_q;
    inj_pending_d = inj_pending_q;
    inj_bank_d    = inj_bank_q;
    inj_mask_d    = inj_mask_q;
    bank_we       = '0;
    bank_re       = '0;
    bank_inj_mask = '0;
    for (int b = 0; b < NB; b++) begin
      bank_addr[b]  = bus.dccm_addr_bank[b];
      bank_wdata[b] = {bus.dccm_wr_ecc_bank[b], bus.dccm_wr_data_bank[b]};
    end

    case (state_q)
      EL2_SRAM_INIT: begin
        bank_we    = '1;
        bank_wdata = '0;
        for (int b = 0; b < NB; b++) begin
          bank_addr[b] = row_cnt_q;
        end
        row_cnt_d = row_cnt_q + ROW_W'(1);
        if (row_cnt_q == ROW_W'(ROWS - 1)) begin
          state_d = EL2_SRAM_READY;
        end
      end
      EL2_SRAM_READY: begin
        bank_we = bus.dccm_clken & bus.dccm_wren_bank;
        bank_re = bus.dccm_clken & ~bus.dccm_wren_bank;
        if (inj_pending_q && bank_re[inj_bank_q]) begin
          bank_inj_mask[inj_bank_q] = inj_mask_q;
          inj_pending_d             = 1'b0;
        end
      end
      default: state_d = EL2_SRAM_INIT;
    endcase

    // A fresh arm wins over a same-cycle consume so the new request is never lost.
    if (err_inj_valid) begin
      inj_pending_d = 1'b1;
      inj_bank_d    = err_inj_bank;
      inj_mask_d    = err_inj_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q       <= EL2_SRAM_INIT;
      row_cnt_q     <= '0;
      inj_pending_q <= 1'b0;
      inj_bank_q    <= '0;
      inj_mask_q    <= '0;
    end else begin
      state_q       <= state_d;
      row_cnt_q     <= row_cnt_d;
      inj_pending_q <= inj_pending_d;
      inj_bank_q    <= inj_bank_d;
      inj_mask_q    <= inj_mask_d;
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    el2_dccm_sram_bank #(
      .ROW_W(ROW_W),
      .DW   (DW),
      .EW   (EW)
    ) u_bank (
      .clk     (clk),
      .rst_l   (rst_l),
      .wr_en   (bank_we[b]),
      .rd_en   (bank_re[b]),
      .addr    (bank_addr[b]),
      .wr_data (bank_wdata[b]),
      .inj_mask(bank_inj_mask[b]),
      .rd_data (bank_rd[b])
    );
  end

  always_comb begin
    for (int b = 0; b < NB; b++) begin
      bus.dccm_bank_dout[b] = bank_rd[b][DW-1:0];
      bus.dccm_bank_ecc[b]  = bank_rd[b][EW+DW-1:DW];
    end
  end

  assign init_done       = (state_q == EL2_SRAM_READY);
  assign err_inj_pending = inj_pending_q;

endmodule

// File: tb/tb_el2_dccm_sram_sink.sv
// tb/tb_el2_dccm_sram_sink.sv - directed self-checking bench for el2_dccm_sram_sink
// Geometry: 4 banks, DCCM_BITS=8 -> 16 rows per bank.
module tb_el2_dccm_sram_sink;

  localparam int NB    = 4;
  localparam int ROW_W = 4;
  localparam int DW    = 32;
  localparam int EW    = 7;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  el2_dccm_sram_sink_if #(.NB(NB), .ROW_W(ROW_W), .DW(DW), .EW(EW)) bus ();

  logic          init_done;
  logic          err_inj_valid;
  logic [1:0]    err_inj_bank;
  logic [EW-1:0] err_inj_mask;
  logic          err_inj_pending;

  el2_dccm_sram_sink #(
    .DCCM_NUM_BANKS (4),
    .DCCM_BANK_BITS (2),
    .DCCM_BITS      (8),
    .DCCM_DATA_WIDTH(32),
    .DCCM_ECC_WIDTH (7)
  ) dut (
    .clk            (clk),
    .rst_l          (rst_l),
    .bus            (bus),
    .init_done      (init_done),
    .err_inj_valid  (err_inj_valid),
    .err_inj_bank   (err_inj_bank),
    .err_inj_mask   (err_inj_mask),
    .err_inj_pending(err_inj_pending)
  );

  int checks = 0;
  int failures = 0;
  int n;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dccm_clken        = '0;
    bus.dccm_wren_bank    = '0;
    bus.dccm_addr_bank    = '0;
    bus.dccm_wr_data_bank = '0;
    bus.dccm_wr_ecc_bank  = '0;
    err_inj_valid         = 1'b0;
    err_inj_bank          = '0;
    err_inj_mask          = '0;
  endtask

  task automatic wr(input int b, input int r, input logic [DW-1:0] d, input logic [EW-1:0] e);
    bus.dccm_clken[b]        = 1'b1;
    bus.dccm_wren_bank[b]    = 1'b1;
    bus.dccm_addr_bank[b]    = r[ROW_W-1:0];
    bus.dccm_wr_data_bank[b] = d;
    bus.dccm_wr_ecc_bank[b]  = e;
  endtask

  task automatic rd(input int b, input int r);
    bus.dccm_clken[b]     = 1'b1;
    bus.dccm_wren_bank[b] = 1'b0;
    bus.dccm_addr_bank[b] = r[ROW_W-1:0];
  endtask

  task automatic wait_init(output int cycles);
    cycles = 0;
    while (!init_done && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    idle();
    tick();
    tick();
    checks++; if (bus.dccm_bank_dout !== '0) begin failures++; $display("FAIL reset_dout got=%h exp=0", bus.dccm_bank_dout); end
    checks++; if (bus.dccm_bank_ecc !== '0) begin failures++; $display("FAIL reset_ecc got=%h exp=0", bus.dccm_bank_ecc); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
    checks++; if (err_inj_pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", err_inj_pending); end
    rst_l = 1'b1;
    wait_init(n);
    checks++; if (n !== 16) begin failures++; $display("FAIL init_cycles got=%0d exp=16", n); end
    for (int r = 0; r < 16; r++) begin
      for (int b = 0; b < NB; b++) rd(b, r);
      tick();
      checks++;
      if (bus.dccm_bank_dout !== '0 || bus.dccm_bank_ecc !== '0) begin
        failures++; $display("FAIL init_zero_row%0d got=%h/%h exp=0/0", r, bus.dccm_bank_dout, bus.dccm_bank_ecc);
      end
    end
    idle();
  endtask

  task automatic test_write_read();
    wr(1, 5, 32'hDEADBEEF, 7'h2A);
    tick();
    idle();
    checks++; if (bus.dccm_bank_dout[1] !== 32'h0) begin failures++; $display("FAIL wr_dout_hold got=%h exp=0", bus.dccm_bank_dout[1]); end
    rd(1, 5);
    tick();
    idle();
    checks++; if (bus.dccm_bank_dout[1] !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_b1_data got=%h exp=deadbeef", bus.dccm_bank_dout[1]); end
    checks++; if (bus.dccm_bank_ecc[1] !== 7'h2A) begin failures++; $display("FAIL rd_b1_ecc got=%h exp=2a", bus.dccm_bank_ecc[1]); end
  endtask

  task automatic test_all_banks();
    logic [DW-1:0] d;
    logic [EW-1:0] e;
    for (int b = 0; b < NB; b++) begin
      d = 32'h1000_0001 * (b + 1);
      e = 7'h10 + 7'(b);
      wr(b, 9, d, e);
    end
    tick();
    idle();
    for (int b = 0; b < NB; b++) rd(b, 9);
    tick();
    idle();
    for (int b = 0; b < NB; b++) begin
      d = 32'h1000_0001 * (b + 1);
      e = 7'h10 + 7'(b);
      checks++;
      if (bus.dccm_bank_dout[b] !== d || bus.dccm_bank_ecc[b] !== e) begin
        failures++; $display("FAIL all_banks_b%0d got=%h/%h exp=%h/%h", b, bus.dccm_bank_dout[b], bus.dccm_bank_ecc[b], d, e);
      end
    end
  endtask

  task automatic test_inject();
    wr(2, 5, 32'h12345678, 7'h55);
    tick();
    idle();
    err_inj_valid = 1'b1; err_inj_bank = 2'd2; err_inj_mask = 7'h01;
    rd(2, 5);
    tick();
    idle();
    checks++; if (bus.dccm_bank_ecc[2] !== 7'h55) begin failures++; $display("FAIL inj_arm_cycle_ecc got=%h exp=55", bus.dccm_bank_ecc[2]); end
    checks++; if (err_inj_pending !== 1'b1) begin failures++; $display("FAIL inj_pending_set got=%b exp=1", err_inj_pending); end
    rd(1, 5);
    tick();
    idle();
    checks++; if (err_inj_pending !== 1'b1) begin failures++; $display("FAIL inj_other_bank got=%b exp=1", err_inj_pending); end
    rd(2, 5);
    tick();
    idle();
    checks++; if (bus.dccm_bank_ecc[2] !== 7'h54) begin failures++; $display("FAIL inj_first_ecc got=%h exp=54", bus.dccm_bank_ecc[2]); end
    checks++; if (bus.dccm_bank_dout[2] !== 32'h12345678) begin failures++; $display("FAIL inj_first_data got=%h exp=12345678", bus.dccm_bank_dout[2]); end
    checks++; if (err_inj_pending !== 1'b0) begin failures++; $display("FAIL inj_pending_clear got=%b exp=0", err_inj_pending); end
    rd(2, 5);
    tick();
    idle();
    checks++; if (bus.dccm_bank_ecc[2] !== 7'h55) begin failures++; $display("FAIL inj_second_ecc got=%h exp=55", bus.dccm_bank_ecc[2]); end
    err_inj_valid = 1'b1; err_inj_bank = 2'd0; err_inj_mask = 7'h7F;
    tick();
    err_inj_valid = 1'b1; err_inj_bank = 2'd2; err_inj_mask = 7'h03;
    tick();
    idle();
    rd(0, 0);
    tick();
    idle();
    checks++; if (bus.dccm_bank_ecc[0] !== 7'h00 || err_inj_pending !== 1'b1) begin
      failures++; $display("FAIL inj_overwrite_old got=%h/%b exp=00/1", bus.dccm_bank_ecc[0], err_inj_pending);
    end
    rd(2, 5);
    tick();
    idle();
    checks++; if (bus.dccm_bank_ecc[2] !== 7'h56) begin failures++; $display("FAIL inj_overwrite_new got=%h exp=56", bus.dccm_bank_ecc[2]); end
  endtask

  task automatic test_clken_gate();
    wr(3, 2, 32'hCAFEF00D, 7'h33);
    tick();
    idle();
    rd(3, 2);
    tick();
    idle();
    checks++; if (bus.dccm_bank_dout[3] !== 32'hCAFEF00D) begin failures++; $display("FAIL gate_pre got=%h exp=cafef00d", bus.dccm_bank_dout[3]); end
    bus.dccm_clken[3] = 1'b0; bus.dccm_wren_bank[3] = 1'b1; bus.dccm_addr_bank[3] = 4'd2;
    bus.dccm_wr_data_bank[3] = 32'hBAD0BAD0; bus.dccm_wr_ecc_bank[3] = 7'h7F;
    tick();
    idle();
    checks++; if (bus.dccm_bank_dout[3] !== 32'hCAFEF00D || bus.dccm_bank_ecc[3] !== 7'h33) begin
      failures++; $display("FAIL gate_hold got=%h/%h exp=cafef00d/33", bus.dccm_bank_dout[3], bus.dccm_bank_ecc[3]);
    end
    rd(3, 2);
    tick();
    idle();
    checks++; if (bus.dccm_bank_dout[3] !== 32'hCAFEF00D || bus.dccm_bank_ecc[3] !== 7'h33) begin
      failures++; $display("FAIL gate_row_kept got=%h/%h exp=cafef00d/33", bus.dccm_bank_dout[3], bus.dccm_bank_ecc[3]);
    end
  endtask

  task automatic test_reset_mid();
    rd(1, 5);
    tick();
    idle();
    checks++; if (bus.dccm_bank_dout[1] !== 32'hDEADBEEF) begin failures++; $display("FAIL mid_pre got=%h exp=deadbeef", bus.dccm_bank_dout[1]); end
    rst_l = 1'b0;
    #1;
    checks++; if (bus.dccm_bank_dout !== '0 || bus.dccm_bank_ecc !== '0) begin
      failures++; $display("FAIL mid_async_out got=%h/%h exp=0/0", bus.dccm_bank_dout, bus.dccm_bank_ecc);
    end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL mid_async_done got=%b exp=0", init_done); end
    tick();
    rst_l = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL mid_init_row7 got=%b exp=0", init_done); end
    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
    wait_init(n);
    checks++; if (n !== 16) begin failures++; $display("FAIL mid_restart_cycles got=%0d exp=16", n); end
  endtask

  task automatic test_inject_init();
    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
    err_inj_valid = 1'b1; err_inj_bank = 2'd1; err_inj_mask = 7'h40;
    tick();
    idle();
    checks++; if (err_inj_pending !== 1'b1 || init_done !== 1'b0) begin
      failures++; $display("FAIL init_arm got=%b/%b exp=1/0", err_inj_pending, init_done);
    end
    wait_init(n);
    checks++; if (n !== 15) begin failures++; $display("FAIL init_arm_cycles got=%0d exp=15", n); end
    rd(1, 5);
    tick();
    idle();
    checks++; if (bus.dccm_bank_dout[1] !== 32'h0 || bus.dccm_bank_ecc[1] !== 7'h40 || err_inj_pending !== 1'b0) begin
      failures++; $display("FAIL init_first_read got=%h/%h/%b exp=0/40/0", bus.dccm_bank_dout[1], bus.dccm_bank_ecc[1], err_inj_pending);
    end
    for (int k = 0; k < 3; k++) begin
      int r;
      r = (k == 0) ? 2 : (k == 1) ? 5 : 9;
      for (int b = 0; b < NB; b++) rd(b, r);
      tick();
      idle();
      checks++;
      if (bus.dccm_bank_dout !== '0 || bus.dccm_bank_ecc !== '0) begin
        failures++; $display("FAIL rezero_row%0d got=%h/%h exp=0/0", r, bus.dccm_bank_dout, bus.dccm_bank_ecc);
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_all_banks();
    test_inject();
    test_clken_gate();
    test_reset_mid();
    test_inject_init();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
